// File: rtl/cpu_store_monitor_pkg.sv
// cpu_store_monitor_pkg: store record type and default match constants shared by the monitor and its FIFO.
package cpu_store_monitor_pkg;
    localparam int SEQ_W = 16;
    localparam logic [31:0] MATCH_ADDR_DEF = 32'd84;
    localparam logic [31:0] MATCH_DATA_DEF = 32'd7;

    typedef struct packed {
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [SEQ_W-1:0] seq;
    } store_rec_t;
endpackage

// File: rtl/store_fifo.sv
// store_fifo: synchronous FIFO of store records; a push into a full FIFO is accepted only alongside a pop.
module store_fifo
    import cpu_store_monitor_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  store_rec_t din,
    output logic       full,
    output logic       empty,
    output store_rec_t head
);
    localparam int AW = $clog2(DEPTH);

    store_rec_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/cpu_store_monitor.sv
// cpu_store_monitor: captures core stores into a FIFO with sticky status; CPU_STORE_MONITOR_MATCH_EN enables pass/fail address matching.
module cpu_store_monitor
    import cpu_store_monitor_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] MATCH_ADDR = MATCH_ADDR_DEF,
    parameter logic [31:0] MATCH_DATA = MATCH_DATA_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic [SEQ_W-1:0] out_seq,
    output logic             full,
    output logic             overflow,
    output logic             misaligned,
    output logic             pass,
    output logic             fail
);
    logic [SEQ_W-1:0] seq;
    logic             empty;
    logic             do_pop;
    store_rec_t       head;

    assign out_valid = !empty;
    assign do_pop    = out_valid && out_ready;
    assign out_addr  = head.addr;
    assign out_data  = head.data;
    assign out_seq   = head.seq;

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (memwrite),
        .pop   (do_pop),
        .din   ('{addr: dataadr, data: writedata, seq: seq}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // seq advances on dropped stores too, so gaps in out_seq expose drops
    always_ff @(posedge clk) begin
        if (reset) begin
            seq        <= '0;
            overflow   <= 1'b0;
            misaligned <= 1'b0;
        end else if (memwrite) begin
            seq        <= seq + 1'b1;
            overflow   <= overflow | (full && !do_pop);
            misaligned <= misaligned | (|dataadr[1:0]);
        end
    end

`ifdef CPU_STORE_MONITOR_MATCH_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pass <= 1'b0;
            fail <= 1'b0;
        end else if (memwrite && dataadr == MATCH_ADDR) begin
            pass <= pass | (writedata == MATCH_DATA);
            fail <= fail | (writedata != MATCH_DATA);
        end
    end
`else
    logic [63:0] unused_match;
    assign unused_match = {MATCH_ADDR, MATCH_DATA};
    assign pass = 1'b0;
    assign fail = 1'b0;
`endif
endmodule
